// File: rtl/mul4_eval_pkg.sv
// Shared types and the golden 2x2-bit multiplier used to score evolved
// mul4 individuals. Operands and products are bit-sliced: bit i of every
// word belongs to test case (lane) i.
package mul4_eval_pkg;

  localparam int LANES          = 16;
  localparam int BITS_PER_LANE  = 4;
  localparam int BITS_PER_BATCH = LANES * BITS_PER_LANE;

  typedef logic [LANES-1:0] lane_word_t;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  typedef struct packed {
    lane_word_t g3;
    lane_word_t g2;
    lane_word_t g1;
    lane_word_t g0;
  } golden_t;

  // Bitwise 2x2 unsigned multiply on bit-sliced words: {a1,a0} * {b1,b0}.
  function automatic golden_t golden_mul4(input lane_word_t a1,
                                          input lane_word_t a0,
                                          input lane_word_t b1,
                                          input lane_word_t b0);
    golden_t g;
    g.g0 = a0 & b0;
    g.g1 = (a1 & b0) ^ (a0 & b1);
    g.g2 = (a1 & b1) & ~(a0 & b0);
    g.g3 = a1 & a0 & b1 & b0;
    return g;
  endfunction

endpackage

// File: rtl/mul4_popcount64.sv
// Combinational population count of a 64-bit hit vector (0..64).
module mul4_popcount64 (
  input  logic [63:0] i_bits,
  output logic [6:0]  o_count
);

  logic [6:0] w_sum;

  // Plain adder chain; synthesis folds it into a balanced tree.
  always_comb begin
    w_sum = 7'd0;
    for (int i = 0; i < 64; i++) begin
      w_sum = w_sum + 7'(i_bits[i]);
    end
  end

  assign o_count = w_sum;

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Scores a candidate mul4 individual: accepts NUM_BATCHES bit-sliced result
// batches, counts product bits matching the golden multiplier, and reports
// the accumulated score once per evaluation.
//
// Handshakes: a batch transfers on a rising edge where in_valid && in_ready;
// the score transfers on a rising edge where out_valid && out_ready. Once
// valid is raised, the presented data and valid are held by the producer
// until the transfer edge; score/perfect are held stable while out_valid is
// high and out_ready is low.
//
// Pipeline: transfer edge registers batch hits (stage 1); next edge adds
// them into the accumulator (stage 2); the edge after that moves the final
// sum into the score register and enters REPORT, so out_valid rises exactly
// two cycles after the final transfer.
module mul4_fitness_scorer
  import mul4_eval_pkg::*;
#(
  parameter  int NUM_BATCHES = 4,
  localparam int SCORE_W     = $clog2(BITS_PER_BATCH * NUM_BATCHES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  lane_word_t         a1,
  input  lane_word_t         a0,
  input  lane_word_t         b1,
  input  lane_word_t         b0,
  input  lane_word_t         y3,
  input  lane_word_t         y2,
  input  lane_word_t         y1,
  input  lane_word_t         y0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] score,
  output logic               perfect,
  output state_t             dbg_state
);

  localparam int CNT_W = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
  localparam logic [CNT_W-1:0]   LAST_IDX      = CNT_W'(NUM_BATCHES - 1);
  localparam logic [SCORE_W-1:0] PERFECT_SCORE = SCORE_W'(BITS_PER_BATCH * NUM_BATCHES);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_batch_cnt;
  logic                 r_last_taken;
  logic                 r_s1_valid;
  logic                 r_s1_last;
  logic [6:0]           r_s1_hits;
  logic                 r_s2_last;
  logic [SCORE_W-1:0]   r_acc;
  logic [SCORE_W-1:0]   r_score;
  logic                 r_perfect;

  golden_t              w_golden;
  logic [63:0]          w_hit_vec;
  logic [6:0]           w_batch_hits;
  logic                 w_take;
  logic                 w_is_last;
  logic                 w_report_done;
  logic                 w_sync_clr;

  assign w_golden  = golden_mul4(a1, a0, b1, b0);
  assign w_hit_vec = {~(y3 ^ w_golden.g3), ~(y2 ^ w_golden.g2),
                      ~(y1 ^ w_golden.g1), ~(y0 ^ w_golden.g0)};

  mul4_popcount64 u_popcount (
    .i_bits  (w_hit_vec),
    .o_count (w_batch_hits)
  );

  assign w_take        = in_valid && in_ready;
  assign w_is_last     = (r_batch_cnt == LAST_IDX);
  assign w_report_done = (r_state == REPORT) && out_ready;
  assign w_sync_clr    = !rst_n || clear;

  // State register; reset and clear both abandon the current evaluation.
  always_ff @(posedge clk) begin
    if (w_sync_clr) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: report once the final batch has been accumulated.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (r_s2_last) w_state_nxt = REPORT;
      REPORT:  if (out_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Handshake outputs decoded from state; no batch accepted after the last one.
  always_comb begin
    in_ready  = (r_state == ACCUM) && !r_last_taken;
    out_valid = (r_state == REPORT);
    score     = r_score;
    perfect   = r_perfect;
    dbg_state = r_state;
  end

  // Batch pipeline, accumulator and score capture. Stage-1 data only loads
  // on a transfer, so idle data inputs never reach the accumulator.
  always_ff @(posedge clk) begin
    if (w_sync_clr) begin
      r_batch_cnt  <= '0;
      r_last_taken <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_hits    <= '0;
      r_s2_last    <= 1'b0;
      r_acc        <= '0;
      r_score      <= '0;
      r_perfect    <= 1'b0;
    end else begin
      r_s1_valid <= w_take;
      if (w_take) begin
        r_s1_hits   <= w_batch_hits;
        r_s1_last   <= w_is_last;
        r_batch_cnt <= w_is_last ? '0 : r_batch_cnt + 1'b1;
      end
      r_s2_last <= r_s1_valid && r_s1_last;

      if (w_report_done) begin
        r_acc <= '0;
      end else if (r_s1_valid) begin
        r_acc <= r_acc + SCORE_W'(r_s1_hits);
      end

      if (w_report_done) begin
        r_last_taken <= 1'b0;
        r_batch_cnt  <= '0;
      end else if (w_take && w_is_last) begin
        r_last_taken <= 1'b1;
      end

      if ((r_state == ACCUM) && r_s2_last) begin
        r_score   <= r_acc;
        r_perfect <= (r_acc == PERFECT_SCORE);
      end
    end
  end

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Bench for mul4_fitness_scorer (NUM_BATCHES=4): scenario tasks drive
// batches, an arithmetic lane model pushes expected scores into a queue,
// and the consumer task pops and compares them when a score appears.
module tb_mul4_fitness_scorer;
  import mul4_eval_pkg::*;

  localparam int NB      = 4;
  localparam int SCORE_W = $clog2(64 * NB + 1);

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        a1, a0, b1, b0, y3, y2, y1, y0;
  logic               out_valid;
  logic               out_ready;
  logic [SCORE_W-1:0] score;
  logic               perfect;
  state_t             dbg_state;

  int checks   = 0;
  int failures = 0;
  int model_acc = 0;
  int model_cnt = 0;
  logic [SCORE_W-1:0] exp_q[$];

  mul4_fitness_scorer #(.NUM_BATCHES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1        (a1),
    .a0        (a0),
    .b1        (b1),
    .b0        (b0),
    .y3        (y3),
    .y2        (y2),
    .y1        (y1),
    .y0        (y0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .score     (score),
    .perfect   (perfect),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer multiply per lane, count matching product bits.
  function automatic int model_hits(input logic [15:0] a1v, a0v, b1v, b0v,
                                    input logic [15:0] y3v, y2v, y1v, y0v);
    int h;
    int av;
    int bv;
    logic [3:0] pv;
    logic [3:0] yv;
    h = 0;
    for (int i = 0; i < 16; i++) begin
      av = 2 * int'(a1v[i]) + int'(a0v[i]);
      bv = 2 * int'(b1v[i]) + int'(b0v[i]);
      pv = 4'(av * bv);
      yv = {y3v[i], y2v[i], y1v[i], y0v[i]};
      for (int k = 0; k < 4; k++) if (pv[k] == yv[k]) h++;
    end
    return h;
  endfunction

  // Idle data is randomised so any leak into the score shows up.
  task automatic idle_inputs();
    in_valid = 1'b0;
    a1 = 16'($urandom); a0 = 16'($urandom); b1 = 16'($urandom); b0 = 16'($urandom);
    y3 = 16'($urandom); y2 = 16'($urandom); y1 = 16'($urandom); y0 = 16'($urandom);
  endtask

  // Driver: present one batch, wait for in_ready, return #1 after the transfer edge.
  task automatic send_batch(input logic [15:0] a1v, a0v, b1v, b0v,
                            input logic [15:0] y3v, y2v, y1v, y0v);
    int waited;
    @(negedge clk);
    a1 = a1v; a0 = a0v; b1 = b1v; b0 = b0v;
    y3 = y3v; y2 = y2v; y1 = y1v; y0 = y0v;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_batch_ready: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end else begin
      model_acc += model_hits(a1v, a0v, b1v, b0v, y3v, y2v, y1v, y0v);
      model_cnt++;
      if (model_cnt == NB) begin
        exp_q.push_back(SCORE_W'(model_acc));
        model_acc = 0;
        model_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic send_all_nine();
    send_batch(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF);
  endtask

  // Consumer: wait for a score, compare against the queue head, take it.
  task automatic collect_score(input string name);
    int waited;
    logic [SCORE_W-1:0] exp_s;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL %s_out_valid_timeout: out_valid=0 after %0d cycles, required 1", name, waited);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_unexpected_score: score=%0d with no expected entry", name, score);
      return;
    end
    exp_s = exp_q.pop_front();
    if (score !== exp_s) begin
      failures++;
      $display("FAIL %s_score: got %0d, required %0d", name, score, exp_s);
    end
    checks++;
    if (perfect !== (exp_s == SCORE_W'(64 * NB))) begin
      failures++;
      $display("FAIL %s_perfect: got %0b, required %0b", name, perfect, (exp_s == SCORE_W'(64 * NB)));
    end
    checks++;
    if (dbg_state !== REPORT) begin
      failures++;
      $display("FAIL %s_state: got %0d, required REPORT", name, dbg_state);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_release: out_valid=%0b in_ready=%0b, required 0 and 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    checks++;
    if (score !== '0) begin failures++; $display("FAIL reset_score: got %0d, required 0", score); end
    checks++;
    if (perfect !== 1'b0) begin failures++; $display("FAIL reset_perfect: got %0b, required 0", perfect); end
  endtask

  // All lanes 3x3=9, plus exact latency check on the final transfer.
  task automatic test_perfect_latency();
    logic [2:0] seen;
    for (int b = 0; b < NB; b++) send_all_nine();
    @(negedge clk); seen[0] = out_valid;   // between transfer edge and +1
    @(negedge clk); seen[1] = out_valid;   // after +1 edge
    @(negedge clk); seen[2] = out_valid;   // after +2 edge
    checks++;
    if (seen !== 3'b100) begin
      failures++;
      $display("FAIL perfect_latency: out_valid after edges +0/+1/+2 = %b, required 100", {seen[2], seen[1], seen[0]});
    end
    collect_score("perfect");
  endtask

  task automatic test_one_bad_bit();
    send_all_nine();
    send_batch(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFE);
    send_all_nine();
    send_all_nine();
    collect_score("one_bad_bit");
  endtask

  task automatic test_zero_score();
    for (int b = 0; b < NB; b++)
      send_batch(16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    collect_score("zero_score");
  endtask

  task automatic test_backpressure();
    int waited;
    logic [SCORE_W-1:0] held;
    for (int b = 0; b < NB; b++) send_all_nine();
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 20) begin @(negedge clk); waited++; end
    held = score;
    for (int c = 0; c < 5; c++) begin
      // Extra batch attempts while the score is pending must be refused.
      in_valid = 1'b1;
      a1 = 16'h0; a0 = 16'h0; b1 = 16'h0; b0 = 16'h0;
      y3 = 16'h0; y2 = 16'h0; y1 = 16'h0; y0 = 16'h0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || score !== held || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold: out_valid=%0b score=%0d in_ready=%0b, required 1 %0d 0",
                 out_valid, score, in_ready, held);
      end
    end
    idle_inputs();
    collect_score("backpressure");
  endtask

  // Exhaustive lane operands (lane i: A=i[3:2], B=i[1:0]) with random gaps.
  task automatic test_random_gaps();
    logic [15:0] ya3, ya2, ya1, ya0;
    logic [3:0] pv;
    for (int i = 0; i < 16; i++) begin
      pv = 4'((i >> 2) * (i & 3));
      ya3[i] = pv[3]; ya2[i] = pv[2]; ya1[i] = pv[1]; ya0[i] = pv[0];
    end
    for (int b = 0; b < NB; b++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_batch(16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, ya3, ya2, ya1, ya0);
    end
    collect_score("random_gaps");
    // Random candidates: partial scores exercise the accumulator.
    for (int b = 0; b < NB; b++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_batch(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    collect_score("random_data");
  endtask

  // Abort after two batches via reset or clear; next evaluation starts fresh.
  task automatic test_abort(input bit use_clear);
    logic seen;
    send_all_nine();
    send_all_nine();
    @(negedge clk);
    if (use_clear) clear = 1'b1; else rst_n = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    rst_n = 1'b1;
    model_acc = 0;
    model_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_%0d_idle: out_valid seen=%0b in_ready=%0b, required 0 and 1", use_clear, seen, in_ready);
    end
    for (int b = 0; b < NB; b++) send_all_nine();
    collect_score(use_clear ? "abort_clear" : "abort_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    test_reset();
    test_perfect_latency();
    test_one_bad_bit();
    test_zero_score();
    test_backpressure();
    test_random_gaps();
    test_abort(1'b0);
    test_abort(1'b1);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected scores never produced, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mul4_fitness_scorer.md
Name: mul4_fitness_scorer

Overview:
- Downstream consumer of an evolved mul4 individual; scores how well the individual implements a 2x2-bit unsigned multiplier.
- Each 16-bit operand/result word is bit-sliced: lane i (0..15) carries one test case.
  - A = {a1[i],a0[i]}
  - B = {b1[i],b0[i]}
  - Candidate product = {y3[i],y2[i],y1[i],y0[i]}
- The block accepts NUM_BATCHES result batches over a valid/ready handshake, computes the golden product per lane and counts correct output bits. It then reports one accumulated fitness score to the tournament selector.

Parameters:
- NUM_BATCHES, 4, batches accumulated per score; minimum 1.
- SCORE_W, $clog2(64*NUM_BATCHES+1), score width; derived, not overridable.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- clear  input  1  synchronous restart of the current evaluation
- in_valid  input  1  batch present
- in_ready  output  1  block can accept a batch
- a1, a0, b1, b0  input  16 each  bit-sliced operands
- y3, y2, y1, y0  input  16 each  bit-sliced candidate product
- out_valid  output  1  score available
- out_ready  input  1  consumer takes score
- score  output  SCORE_W  number of correct product bits, 0..64*NUM_BATCHES
- perfect  output  1  score == 64*NUM_BATCHES

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=ACCUM; in_ready=1; out_valid=0; score=0; perfect=0.
  - Batch counter=0; accumulator=0; stage-1 valid=0.
- Golden product per lane:
  - g0 = a0&b0
  - g1 = (a1&b0)^(a0&b1)
  - g2 = (a1&b1)&~(a0&b0)
  - g3 = a1&a0&b1&b0
  - Pure bitwise on the 16-bit words.
- Hit vector = ~(y3^g3), ~(y2^g2), ~(y1^g1), ~(y0^g0): 64 bits.
- Batch hits = popcount of the hit vector, 0..64, 7 bits.
- Transfer occurs when in_valid && in_ready.
- Stage 1 (registered, 1 cycle):
  - On a transfer, register batch hits, s1_valid=1, and s1_last=(batch counter==NUM_BATCHES-1).
  - Increment the batch counter; it wraps to 0 after the last batch.
- Stage 2: when s1_valid, accumulator += batch hits. Accumulator width is SCORE_W and cannot overflow.
- in_ready = (state==ACCUM) && !last_taken, where last_taken is set when the final batch transfers.
  - After the final batch, no further batch is accepted until the score handshake completes.
- States:
  - ACCUM → REPORT when stage 2 consumes s1_last.
    - score = accumulator + final hits; out_valid=1; perfect computed from that score.
  - REPORT → ACCUM on out_valid && out_ready.
    - Clear accumulator, last_taken and the batch counter.
    - in_ready rises on the following cycle.
- Latency: out_valid asserts exactly 2 cycles after the clock edge that transfers the final batch.
- Backpressure: score and perfect are held stable while out_valid && !out_ready.
- in_valid gaps between batches are allowed; the accumulation is unaffected.
- clear=1, at any time and in any state:
  - Same effect as reset except that rst_n priority is kept (rst_n wins).
  - Any in-flight batch in the same cycle is discarded.
- Reset or clear mid-evaluation drops partial sums; no score is emitted for that evaluation.
- Data inputs are ignored when in_valid=0. X on data inputs with in_valid=0 must not propagate.

Decomposition:
- Package mul4_eval_pkg:
  - LANES=16; BITS_PER_LANE=4; BITS_PER_BATCH=64.
  - Typedef lane_word_t (logic [15:0]).
  - Typedef state_t enum {ACCUM, REPORT}.
  - Function golden_mul4 returning the four golden words.
- Sub-module mul4_popcount64: 64-bit input, 7-bit count output, combinational. Instantiated once, feeding stage 1.

Test Plan:
- NUM_BATCHES=4; each batch a1=a0=b1=b0=16'hFFFF, y3=16'hFFFF, y2=y1=0, y0=16'hFFFF (3×3=9) → score=256, perfect=1, out_valid exactly 2 cycles after 4th transfer.
- Same as first, but batch 2 has y0=16'hFFFE → score=255, perfect=0.
- All inputs 0 and all y words 16'hFFFF in every batch → score=0, perfect=0.
- Hold out_ready=0 for 5 cycles after out_valid → score and out_valid stable, in_ready=0, extra in_valid pulses ignored. Then out_ready=1 → out_valid drops next cycle, in_ready=1.
- Random in_valid gaps with exhaustive lane operand coverage (lane i: A=i[3:2], B=i[1:0]) and correct y → score=256.
- Assert rst_n=0 (then clear=1 in a second run) after 2 batches → no out_valid. The next full 4-batch evaluation scores 256, not 256 plus earlier hits.
